// File: rtl/axi4_pkg.sv
// axi4_pkg: AXI4 field widths, burst and response encodings shared by the DMA write path
package axi4_pkg;
   localparam int BURST_BITS = 2;
   localparam int LEN_BITS = 8;
   localparam int SIZE_BITS = 3;
   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR = 2'd1;
   localparam logic [1:0] BURST_WRAP = 2'd2;
   localparam logic [1:0] RESP_OKAY = 2'd0;
   localparam logic [1:0] RESP_EXOKAY = 2'd1;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;
   localparam int BOUNDARY_4K = 4096;
endpackage

// File: rtl/dmac_wr_burst_calc.sv
// dmac_wr_burst_calc: sizes the next AW burst and the address/count that follow it
module dmac_wr_burst_calc
   import axi4_pkg::*;
#(
   parameter int ADDR_WD = 32,
   parameter int MAX_BURST_LEN = 16
) (
   input  logic [ADDR_WD-1:0]    addr,
   input  logic [ADDR_WD-1:0]    remaining,
   input  logic [SIZE_BITS-1:0]  size,
   input  logic [BURST_BITS-1:0] burst,
   output logic [8:0]            beats,
   output logic [LEN_BITS-1:0]   wr_req_len,
   output logic [ADDR_WD-1:0]    next_addr,
   output logic [ADDR_WD-1:0]    next_remaining,
   output logic                  last
);
   logic [12:0] raw_bnd, bnd, cap;
   always_comb begin
      raw_bnd = (13'(BOUNDARY_4K) - {1'b0, addr[11:0]}) >> size;
      bnd = raw_bnd == '0 ? 13'd1 : raw_bnd;
      cap = burst == BURST_INCR ? (bnd < 13'(MAX_BURST_LEN) ? bnd : 13'(MAX_BURST_LEN)) : 13'd16;
      beats = remaining < ADDR_WD'(cap) ? 9'(remaining) : 9'(cap);
      wr_req_len = beats == '0 ? '0 : LEN_BITS'(beats - 9'd1);
      next_addr = burst == BURST_INCR ? ((addr >> size) << size) + (ADDR_WD'(beats) << size) : addr;
      next_remaining = remaining - ADDR_WD'(beats);
      last = next_remaining == '0;
   end
endmodule

// File: rtl/dmac_write_req_gen.sv
// dmac_write_req_gen: splits a DMA write command into AXI4 AW bursts and reports one completion
module dmac_write_req_gen
   import axi4_pkg::*;
#(
   parameter int ADDR_WD = 32,
   parameter int MAX_BURST_LEN = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WD-1:0]    cmd_dst_addr,
   input  logic [BURST_BITS-1:0] cmd_burst,
   input  logic [ADDR_WD-1:0]    cmd_len,
   input  logic [SIZE_BITS-1:0]  cmd_size,
   output logic                  wr_req_valid,
   input  logic                  wr_req_ready,
   output logic [ADDR_WD-1:0]    wr_req_addr,
   output logic [BURST_BITS-1:0] wr_req_burst,
   output logic [LEN_BITS-1:0]   wr_req_len,
   output logic [SIZE_BITS-1:0]  wr_req_size,
   input  logic                  bresp_valid,
   output logic                  bresp_ready,
   input  logic [1:0]            bresp,
   output logic                  done_valid,
   input  logic                  done_ready,
   output logic                  done_error
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t state_q, state_d;
   logic [ADDR_WD-1:0] addr_q, addr_d, rem_q, rem_d, next_addr, next_rem;
   logic [BURST_BITS-1:0] burst_q, burst_d;
   logic [SIZE_BITS-1:0] size_q, size_d;
   logic [CW-1:0] out_q, out_d;
   logic err_q, err_d, last, aw_fire, b_fire;
   logic [8:0] beats;

   dmac_wr_burst_calc #(.ADDR_WD(ADDR_WD), .MAX_BURST_LEN(MAX_BURST_LEN)) u_calc (
      .addr(addr_q),
      .remaining(rem_q),
      .size(size_q),
      .burst(burst_q),
      .beats(beats),
      .wr_req_len(wr_req_len),
      .next_addr(next_addr),
      .next_remaining(next_rem),
      .last(last)
   );

   assign cmd_ready = state_q == IDLE;
   assign wr_req_valid = state_q == ISSUE && out_q < CW'(MAX_OUTSTANDING) && beats != '0;
   assign bresp_ready = out_q != '0;
   assign done_valid = state_q == DONE;
   assign done_error = err_q;
   assign wr_req_addr = addr_q;
   assign wr_req_burst = burst_q;
   assign wr_req_size = size_q;
   assign aw_fire = wr_req_valid & wr_req_ready;
   assign b_fire = bresp_valid & bresp_ready;

   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      rem_d = rem_q;
      burst_d = burst_q;
      size_d = size_q;
      err_d = err_q | (b_fire && bresp >= RESP_SLVERR);
      out_d = out_q + CW'(aw_fire) - CW'(b_fire);
      case (state_q)
         IDLE: if (cmd_valid) begin
            addr_d = cmd_dst_addr;
            rem_d = cmd_len;
            burst_d = cmd_burst;
            size_d = cmd_size;
            err_d = cmd_burst > BURST_INCR;
            state_d = (cmd_burst > BURST_INCR || cmd_len == '0) ? DONE : ISSUE;
         end
         ISSUE: if (aw_fire) begin
            addr_d = next_addr;
            rem_d = next_rem;
            state_d = last ? DRAIN : ISSUE;
         end
         DRAIN: state_d = (out_q == '0 || (out_q == CW'(1) && b_fire)) ? DONE : DRAIN;
         DONE: if (done_ready) begin
            err_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q <= '0;
         rem_q <= '0;
         burst_q <= '0;
         size_q <= '0;
         out_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         rem_q <= rem_d;
         burst_q <= burst_d;
         size_q <= size_d;
         out_q <= out_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_dmac_write_req_gen.sv
// tb_dmac_write_req_gen: randomized and directed checks of the write request generator against a burst-list model
module tb_dmac_write_req_gen;
   localparam int MBL = 16;
   localparam int MO = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cmd_valid = 1'b0, cmd_ready;
   logic [31:0] cmd_dst_addr = '0, cmd_len = '0;
   logic [1:0] cmd_burst = '0;
   logic [2:0] cmd_size = '0;
   logic wr_req_valid, wr_req_ready = 1'b0;
   logic [31:0] wr_req_addr;
   logic [1:0] wr_req_burst;
   logic [7:0] wr_req_len;
   logic [2:0] wr_req_size;
   logic bresp_valid = 1'b0, bresp_ready;
   logic [1:0] bresp = '0;
   logic done_valid, done_ready = 1'b0, done_error;

   int vec = 0, miss = 0, pend = 0, aw_cnt = 0, b_idx = 0;
   bit err_exp, done_seen, done_err_seen, expect_done;
   logic [31:0] exp_addr[$];
   logic [7:0] exp_len[$];
   logic [1:0] cur_burst;
   logic [2:0] cur_size;

   always #5 clk = ~clk;

   dmac_write_req_gen #(.ADDR_WD(32), .MAX_BURST_LEN(MBL), .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dst_addr(cmd_dst_addr),
      .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_size(cmd_size),
      .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
      .wr_req_burst(wr_req_burst), .wr_req_len(wr_req_len), .wr_req_size(wr_req_size),
      .bresp_valid(bresp_valid), .bresp_ready(bresp_ready), .bresp(bresp),
      .done_valid(done_valid), .done_ready(done_ready), .done_error(done_error)
   );

   // Expected burst list: each burst is the largest legal chunk from the current address.
   task automatic model(input logic [31:0] a, input logic [1:0] bu, input logic [31:0] len, input logic [2:0] sz);
      longint rem, b, bnd, unit;
      exp_addr.delete();
      exp_len.delete();
      rem = len;
      unit = longint'(1) << sz;
      if (bu >= 2) return;
      while (rem > 0) begin
         bnd = (4096 - longint'(a % 4096)) / unit;
         if (bnd == 0) bnd = 1;
         b = (bu == 1) ? ((bnd < MBL) ? bnd : MBL) : 16;
         if (rem < b) b = rem;
         exp_addr.push_back(a);
         exp_len.push_back(8'(b - 1));
         if (bu == 1) a = 32'(longint'(a) - longint'(a) % unit + b * unit);
         rem -= b;
      end
   endtask

   task automatic step(input bit ar, input bit bv, input logic [1:0] bval, input bit dr);
      bit awf, bf;
      wr_req_ready = ar;
      bresp_valid = bv;
      bresp = bval;
      done_ready = dr;
      #1;
      if (expect_done) begin
         vec++;
         if (done_valid !== 1'b1) begin miss++; $display("FAIL done_latency got=%b want=1", done_valid); end
         expect_done = 0;
      end
      vec++;
      if (bresp_ready !== (pend > 0)) begin miss++; $display("FAIL bresp_ready got=%b want=%0d", bresp_ready, pend > 0); end
      awf = wr_req_valid && ar;
      bf = bv && bresp_ready;
      if (awf) begin
         vec++;
         if (exp_addr.size() == 0) begin
            miss++; $display("FAIL aw_extra got addr=%h len=%0d want none", wr_req_addr, wr_req_len);
         end else begin
            if ({wr_req_addr, wr_req_len, wr_req_burst, wr_req_size} !== {exp_addr[0], exp_len[0], cur_burst, cur_size}) begin
               miss++;
               $display("FAIL aw_fields got addr=%h len=%0d burst=%0d size=%0d want addr=%h len=%0d burst=%0d size=%0d",
                        wr_req_addr, wr_req_len, wr_req_burst, wr_req_size, exp_addr[0], exp_len[0], cur_burst, cur_size);
            end
            void'(exp_addr.pop_front());
            void'(exp_len.pop_front());
         end
         aw_cnt++;
         pend++;
      end
      if (bf) begin
         pend--;
         err_exp |= bval[1];
         b_idx++;
         if (pend == 0 && exp_addr.size() == 0) expect_done = 1;
      end
      if (done_valid && dr) begin
         vec++;
         if (done_error !== err_exp || exp_addr.size() != 0 || pend != 0) begin
            miss++;
            $display("FAIL done got err=%b left_aw=%0d pend=%0d want err=%b left_aw=0 pend=0", done_error, exp_addr.size(), pend, err_exp);
         end
         done_seen = 1;
         done_err_seen = done_error;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [31:0] a, input logic [1:0] bu, input logic [31:0] len, input logic [2:0] sz);
      int t = 0;
      wr_req_ready = 0; bresp_valid = 0; done_ready = 0;
      while (cmd_ready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
      vec++;
      if (cmd_ready !== 1'b1) begin miss++; $display("FAIL cmd_ready_wait got=%b want=1", cmd_ready); end
      model(a, bu, len, sz);
      cur_burst = bu; cur_size = sz;
      err_exp = bu[1]; done_seen = 0; b_idx = 0; expect_done = 0;
      cmd_valid = 1; cmd_dst_addr = a; cmd_burst = bu; cmd_len = len; cmd_size = sz;
      @(posedge clk);
      #1;
      cmd_valid = 0;
      vec++;
      if (bu[1] || len == 0) begin
         if (done_valid !== 1'b1 || cmd_ready !== 1'b0) begin miss++; $display("FAIL cmd_to_done got done=%b rdy=%b want 1 0", done_valid, cmd_ready); end
      end else if (wr_req_valid !== 1'b1 || cmd_ready !== 1'b0) begin
         miss++; $display("FAIL cmd_to_aw got valid=%b rdy=%b want 1 0", wr_req_valid, cmd_ready);
      end
   endtask

   task automatic run_to_done(input int mode);
      int n = 0;
      logic [1:0] r;
      while (!done_seen && n < 3000) begin
         r = mode == 0 ? 2'b00 : mode == 1 ? (($urandom % 4 == 0) ? 2'($urandom) : 2'b00) : (b_idx == 1 ? 2'b10 : 2'b00);
         step($urandom % 4 != 0, pend > 0 && $urandom % 3 != 0, r, $urandom % 2 == 0);
         n++;
      end
      vec++;
      if (!done_seen) begin miss++; $display("FAIL done_timeout got none want done within 3000 cycles"); end
   endtask

   task automatic check_reset_vals(input string tag);
      vec++;
      if ({cmd_ready, wr_req_valid, bresp_ready, done_valid, done_error, wr_req_addr, wr_req_len, wr_req_burst, wr_req_size} !== {1'b1, 4'b0, 45'b0}) begin
         miss++;
         $display("FAIL %s got rdy=%b v=%b br=%b dv=%b de=%b a=%h l=%0d b=%0d s=%0d want 1 0 0 0 0 0 0 0 0", tag,
                  cmd_ready, wr_req_valid, bresp_ready, done_valid, done_error, wr_req_addr, wr_req_len, wr_req_burst, wr_req_size);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset_values");
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_incr_split();
      int c = aw_cnt;
      send_cmd(32'h1000, 2'd1, 32'd40, 3'd2);
      run_to_done(0);
      vec++;
      if (aw_cnt - c != 3 || done_err_seen !== 1'b0) begin miss++; $display("FAIL incr_split got aws=%0d err=%b want 3 0", aw_cnt - c, done_err_seen); end
   endtask

   task automatic test_4k_cross();
      int c = aw_cnt;
      send_cmd(32'h0FF0, 2'd1, 32'd10, 3'd2);
      run_to_done(0);
      vec++;
      if (aw_cnt - c != 2) begin miss++; $display("FAIL cross_4k got aws=%0d want 2", aw_cnt - c); end
   endtask

   task automatic test_outstanding();
      int c = aw_cnt;
      send_cmd(32'h0, 2'd1, 32'd64, 3'd2);
      repeat (8) step(1, 0, 2'b00, 0);
      vec++;
      if (aw_cnt - c != MO || wr_req_valid !== 1'b0) begin miss++; $display("FAIL outstanding_cap got aws=%0d valid=%b want %0d 0", aw_cnt - c, wr_req_valid, MO); end
      step(1, 1, 2'b00, 0);
      vec++;
      if (wr_req_valid !== 1'b1) begin miss++; $display("FAIL outstanding_release got valid=%b want 1", wr_req_valid); end
      step(1, 0, 2'b00, 0);
      vec++;
      if (aw_cnt - c != MO + 1) begin miss++; $display("FAIL outstanding_third got aws=%0d want %0d", aw_cnt - c, MO + 1); end
      run_to_done(0);
   endtask

   task automatic test_errors();
      int c;
      send_cmd(32'h4000, 2'd1, 32'd40, 3'd2);
      run_to_done(2);
      vec++;
      if (done_err_seen !== 1'b1) begin miss++; $display("FAIL slverr got err=%b want 1", done_err_seen); end
      c = aw_cnt;
      send_cmd(32'h5000, 2'd2, 32'd10, 3'd2);
      run_to_done(0);
      vec++;
      if (aw_cnt != c || done_err_seen !== 1'b1) begin miss++; $display("FAIL bad_burst got aws=%0d err=%b want 0 1", aw_cnt - c, done_err_seen); end
      send_cmd(32'h6000, 2'd1, 32'd0, 3'd2);
      run_to_done(0);
      vec++;
      if (aw_cnt != c || done_err_seen !== 1'b0) begin miss++; $display("FAIL empty got aws=%0d err=%b want 0 0", aw_cnt - c, done_err_seen); end
   endtask

   task automatic test_fixed();
      int c = aw_cnt;
      send_cmd(32'h2000, 2'd0, 32'd20, 3'd2);
      run_to_done(1);
      vec++;
      if (aw_cnt - c != 2) begin miss++; $display("FAIL fixed got aws=%0d want 2", aw_cnt - c); end
   endtask

   task automatic test_reset_mid();
      int c;
      send_cmd(32'h1000, 2'd1, 32'd40, 3'd2);
      step(1, 0, 2'b00, 0);
      wr_req_ready = 0;
      #2 rst_n = 0;
      #1 check_reset_vals("reset_mid_issue");
      @(posedge clk);
      #1 rst_n = 1;
      pend = 0;
      expect_done = 0;
      exp_addr.delete();
      exp_len.delete();
      c = aw_cnt;
      send_cmd(32'h3008, 2'd1, 32'd24, 3'd3);
      run_to_done(1);
      vec++;
      if (aw_cnt - c != 2) begin miss++; $display("FAIL after_reset got aws=%0d want 2", aw_cnt - c); end
   endtask

   task automatic test_random();
      logic [31:0] a, len;
      logic [1:0] bu;
      int r;
      for (int i = 0; i < 30; i++) begin
         r = $urandom % 8;
         bu = r < 3 ? 2'd0 : r < 7 ? 2'd1 : 2'(2 + $urandom % 2);
         r = $urandom % 3;
         a = r == 0 ? $urandom : r == 1 ? 32'(4096 * ($urandom % 64 + 1) - $urandom % 200) : 32'hFFFF_FF00 + 32'($urandom % 256);
         len = 32'($urandom % 60);
         send_cmd(a, bu, len, 3'($urandom % 8));
         run_to_done(1);
      end
   endtask

   initial begin
      test_reset();
      test_incr_split();
      test_4k_cross();
      test_outstanding();
      test_errors();
      test_fixed();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
